viterbi_codec: RTL and testbench



---
 rtl/viterbi_codec.sv | 145 ++++++++++++++
 tb/tb_viterbi_codec.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 (7,5 octal) convolutional encoder looped into a 4-state
// hard-decision register-exchange Viterbi decoder; one symbol every two clocks.
module viterbi_codec #(
    parameter int DEPTH = 8,
    parameter int PMW   = 5
) (
    input  logic Clock,
    input  logic reset,
    input  logic in,
    input  logic error,
    output logic out,
    output logic decoded
);

    typedef enum logic {
        PH_C0 = 1'b0,
        PH_C1 = 1'b1
    } phase_e;

    localparam logic [PMW-1:0] PM_INIT = PMW'(4);

    phase_e                    phase_q, phase_d;
    logic [1:0]                enc_s_q, enc_s_d;
    logic                      c1_q, c1_d;
    logic                      out_q, out_d;
    logic                      r0_q, r0_d;
    logic [3:0][PMW-1:0]       pm_q, pm_d;
    logic [3:0][DEPTH-1:0]     surv_q, surv_d;
    logic                      decoded_q, decoded_d;

    logic                      rx;
    logic [3:0][PMW-1:0]       cand_w;
    logic [3:0][1:0]           pred_w;
    logic [PMW-1:0]            min_w;
    logic [1:0]                best_w;
    logic [1:0]                ns_b, pa, pb;
    logic [PMW-1:0]            ma, mb;

    // Hamming distance between received pair and the transition's code pair.
    function automatic logic [1:0] branch_metric(input logic [1:0] pred, input logic u,
                                                 input logic r0, input logic r1);
        logic c0, c1;
        c0 = u ^ pred[1] ^ pred[0];
        c1 = u ^ pred[0];
        return {1'b0, r0 ^ c0} + {1'b0, r1 ^ c1};
    endfunction

    function automatic logic [PMW-1:0] sat_add(input logic [PMW-1:0] a, input logic [1:0] b);
        logic [PMW:0] sum;
        sum = {1'b0, a} + {{(PMW-1){1'b0}}, b};
        return sum[PMW] ? {PMW{1'b1}} : sum[PMW-1:0];
    endfunction

    assign rx = out_q ^ error;

    // Next state ns = {u, p[1]}: predecessors are {ns[0],0} and {ns[0],1}.
    always_comb begin
        cand_w = '0;
        pred_w = '0;
        ns_b   = '0;
        pa     = '0;
        pb     = '0;
        ma     = '0;
        mb     = '0;
        for (int ns = 0; ns < 4; ns++) begin
            ns_b = 2'(ns);
            pa   = {ns_b[0], 1'b0};
            pb   = {ns_b[0], 1'b1};
            ma   = sat_add(pm_q[pa], branch_metric(pa, ns_b[1], r0_q, rx));
            mb   = sat_add(pm_q[pb], branch_metric(pb, ns_b[1], r0_q, rx));
            if (mb < ma) begin
                cand_w[ns] = mb;
                pred_w[ns] = pb;
            end else begin
                cand_w[ns] = ma;
                pred_w[ns] = pa;
            end
        end
    end

    always_comb begin
        min_w  = cand_w[0];
        best_w = 2'd0;
        for (int ns = 1; ns < 4; ns++) begin
            if (cand_w[ns] < min_w) begin
                min_w  = cand_w[ns];
                best_w = 2'(ns);
            end
        end
    end

    always_comb begin
        phase_d   = (phase_q == PH_C0) ? PH_C1 : PH_C0;
        enc_s_d   = enc_s_q;
        c1_d      = c1_q;
        out_d     = out_q;
        r0_d      = r0_q;
        pm_d      = pm_q;
        surv_d    = surv_q;
        decoded_d = decoded_q;
        if (phase_q == PH_C0) begin
            out_d   = in ^ enc_s_q[1] ^ enc_s_q[0];
            c1_d    = in ^ enc_s_q[0];
            enc_s_d = {in, enc_s_q[1]};
            for (int ns = 0; ns < 4; ns++) begin
                pm_d[ns]   = cand_w[ns] - min_w;
                surv_d[ns] = {surv_q[pred_w[ns]][DEPTH-2:0], ns[1]};
            end
            // The bit shifted out of the best path is the decision DEPTH symbols back.
            decoded_d = surv_q[pred_w[best_w]][DEPTH-1];
        end else begin
            out_d = c1_q;
            r0_d  = rx;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            phase_q   <= PH_C0;
            enc_s_q   <= '0;
            c1_q      <= 1'b0;
            out_q     <= 1'b0;
            r0_q      <= 1'b0;
            pm_q[0]   <= '0;
            pm_q[1]   <= PM_INIT;
            pm_q[2]   <= PM_INIT;
            pm_q[3]   <= PM_INIT;
            surv_q    <= '0;
            decoded_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            enc_s_q   <= enc_s_d;
            c1_q      <= c1_d;
            out_q     <= out_d;
            r0_q      <= r0_d;
            pm_q      <= pm_d;
            surv_q    <= surv_d;
            decoded_q <= decoded_d;
        end
    end

    assign out     = out_q;
    assign decoded = decoded_q;

endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: trellis-enumerating full-path Viterbi model,
// per-cycle scoreboard on out/decoded/metrics, plus literal directed checks.
module tb_viterbi_codec;

    localparam int DEPTH  = 8;
    localparam int PMW    = 5;
    localparam int PM_MAX = (1 << PMW) - 1;
    localparam int W      = 2 + 4 * PMW;
    localparam int MAXS   = 2048;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic in_b    = 1'b0;
    logic error_b = 1'b0;
    logic out_w;
    logic decoded_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] push_v;

    // Model state: encoder history, received c0, metrics and complete decided paths.
    int m_phase, m_u1, m_u2, m_c1, m_out, m_r0, m_dec, m_len, m_rx;
    int m_pm[4];
    bit m_path[4][MAXS];
    bit n_path[4][MAXS];

    always #5 clk = ~clk;

    viterbi_codec #(.DEPTH(DEPTH), .PMW(PMW)) dut (
        .Clock   (clk),
        .reset   (reset),
        .in      (in_b),
        .error   (error_b),
        .out     (out_w),
        .decoded (decoded_w)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // One Viterbi step over all 8 trellis transitions (from p with input u).
    task automatic model_acs(input int r0, input int r1);
        int best_m[4];
        int best_p[4];
        int n, c0, c1, m, mn, bst;
        for (int k = 0; k < 4; k++) begin
            best_m[k] = -1;
            best_p[k] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                n  = 2 * u + (p >> 1);
                c0 = u ^ (p >> 1) ^ (p & 1);
                c1 = u ^ (p & 1);
                m  = m_pm[p] + int'(r0 != c0) + int'(r1 != c1);
                if (m > PM_MAX) m = PM_MAX;
                if (best_m[n] < 0 || m < best_m[n]) begin
                    best_m[n] = m;
                    best_p[n] = p;
                end
            end
        end
        mn = best_m[0];
        for (int k = 1; k < 4; k++) if (best_m[k] < mn) mn = best_m[k];
        bst = -1;
        for (int k = 0; k < 4; k++) begin
            m_pm[k] = best_m[k] - mn;
            if (bst < 0 && m_pm[k] == 0) bst = k;
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < m_len; i++) n_path[k][i] = m_path[best_p[k]][i];
            n_path[k][m_len] = bit'(k >> 1);
        end
        m_len++;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < m_len; i++) m_path[k][i] = n_path[k][i];
        m_dec = (m_len - 1 - DEPTH >= 0) ? int'(m_path[bst][m_len - 1 - DEPTH]) : 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_u1 = 0; m_u2 = 0; m_c1 = 0; m_out = 0; m_r0 = 0; m_dec = 0;
            m_len = 0;
            m_pm[0] = 0; m_pm[1] = 4; m_pm[2] = 4; m_pm[3] = 4;
        end else begin
            m_rx = m_out ^ int'(error_b);
            if (m_phase == 0) begin
                model_acs(m_r0, m_rx);
                m_out = int'(in_b) ^ m_u1 ^ m_u2;
                m_c1  = int'(in_b) ^ m_u2;
                m_u2  = m_u1;
                m_u1  = int'(in_b);
            end else begin
                m_r0  = m_rx;
                m_out = m_c1;
            end
            m_phase = 1 - m_phase;
        end
        push_v        = '0;
        push_v[W-1]   = m_out[0];
        push_v[W-2]   = m_dec[0];
        for (int i = 0; i < 4; i++) push_v[i*PMW +: PMW] = PMW'(m_pm[i]);
        exp_q.push_back(push_v);
    end

    always @(negedge clk) begin
        logic [4*PMW-1:0] act_pm;
        if (exp_q.size() > 0) begin
            exp_v  = exp_q.pop_front();
            act_pm = dut.pm_q;
            check("out", int'(out_w), int'(exp_v[W-1]));
            check("decoded", int'(decoded_w), int'(exp_v[W-2]));
            for (int i = 0; i < 4; i++)
                check("path_metric", int'(act_pm[i*PMW +: PMW]), int'(exp_v[i*PMW +: PMW]));
        end
    end

    // Called at a negedge with the next rising edge being a phase-0 edge.
    // ea flips the previous symbol's c1, eb flips this symbol's c0.
    task automatic sym(input bit u, input bit ea, input bit eb,
                       output bit o0, output bit o1, output bit od);
        in_b    = u;
        error_b = ea;
        @(posedge clk);
        #1;
        o0 = out_w;
        od = decoded_w;
        @(negedge clk);
        error_b = eb;
        in_b    = 1'($urandom);
        @(posedge clk);
        #1;
        o1 = out_w;
        @(negedge clk);
        error_b = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        error_b = 1'($urandom);
        repeat (cycles) @(negedge clk);
        reset   = 1'b0;
        error_b = 1'b0;
    endtask

    initial begin
        bit ob0, ob1, od;
        bit pat[9];
        bit uh[64];
        bit dl[64];
        int exp_o[6];
        pat   = '{0, 1, 0, 1, 1, 1, 0, 0, 1};
        exp_o = '{1, 1, 1, 0, 1, 1};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            sym(1'b0, 1'b0, 1'b0, ob0, ob1, od);
            check("zeros_out", int'(ob0 | ob1), 0);
            check("zeros_dec", int'(od), 0);
        end

        do_reset(2);
        for (int k = 0; k < DEPTH + 4; k++) begin
            sym((k == 0), 1'b0, 1'b0, ob0, ob1, od);
            if (k < 3) begin
                check("impulse_c0", int'(ob0), exp_o[2*k]);
                check("impulse_c1", int'(ob1), exp_o[2*k+1]);
            end
            check("impulse_dec", int'(od), (k == DEPTH + 1) ? 1 : 0);
        end

        for (int pass = 0; pass < 2; pass++) begin
            do_reset(2);
            for (int k = 0; k < 9 + DEPTH + 2; k++) begin
                sym((k < 9) ? pat[k] : 1'b0, (pass == 1 && k == 4), 1'b0, ob0, ob1, od);
                dl[k] = od;
            end
            for (int k = 0; k < 9; k++)
                check(pass == 0 ? "pattern_dec" : "pattern_err_dec", int'(dl[k + DEPTH + 1]), int'(pat[k]));
        end

        for (int k = 0; k < 5; k++) sym(1'($urandom), 1'b0, 1'b0, ob0, ob1, od);
        in_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        error_b = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out", int'(out_w), 0);
        check("midreset_dec", int'(decoded_w), 0);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        error_b = 1'b0;
        for (int k = 0; k < DEPTH + 5; k++) begin
            sym((k == 0 || k == 1), 1'b0, 1'b0, ob0, ob1, od);
            if (k == 0) begin
                check("restart_c0", int'(ob0), 1);
                check("restart_c1", int'(ob1), 1);
            end
            check("restart_dec", int'(od), (k == DEPTH + 1 || k == DEPTH + 2) ? 1 : 0);
        end

        do_reset(2);
        for (int k = 0; k < 60; k++) begin
            uh[k] = 1'($urandom);
            sym(uh[k], (k == 21 || k == 22), (k == 20 || k == 21), ob0, ob1, od);
            dl[k] = od;
        end
        for (int j = 22 + 2 * DEPTH; j <= 60 - DEPTH - 2; j++)
            check("burst_recovery", int'(dl[j + DEPTH + 1]), int'(uh[j]));

        do_reset(2);
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    in_b = 1'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                end
                do_reset(2);
            end
            sym(1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ob0, ob1, od);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
